// File: rtl/crg_stream_sched.sv
// crg_stream_sched: round-robin burst scheduler that shares one PRNG stream between
// correlated-randomness requesters. It tags each beat with the owner's mode and drives
// the segmented-adder lane configuration. The lane configuration changes only between bursts.
module crg_stream_sched #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned LEN_PRNG = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [3*NUM_REQ-1:0]     width_i,
  input  logic [LEN_W*NUM_REQ-1:0] len_i,
  output logic [NUM_REQ-1:0]       ack_o,
  input  logic                     prng_valid_i,
  input  logic [LEN_PRNG-1:0]      prng_data_i,
  output logic                     prng_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LEN_PRNG-1:0]      out_data_o,
  output logic [NUM_REQ-1:0]       out_mode_o,
  output logic                     out_last_o,
  output logic [2:0]               cfg_width_o,
  output logic [LEN_PRNG-1:0]      cfg_carry_mask_o,
  output logic                     busy_o
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONFIG = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  // Unsupported width encodings fall back to full 256-bit lanes.
  function automatic logic [2:0] coerce_width(input logic [2:0] w);
    logic [2:0] r;
    case (w)
      3'b000, 3'b100, 3'b110, 3'b111: r = w;
      default:                        r = 3'b111;
    endcase
    return r;
  endfunction

  // A set bit breaks the carry chain at that bit position.
  function automatic logic [LEN_PRNG-1:0] make_carry_mask(input logic [2:0] w);
    logic [LEN_PRNG-1:0] m;
    m      = '0;
    m[32]  = ~w[2];
    m[96]  = ~w[2];
    m[160] = ~w[2];
    m[224] = ~w[2];
    m[64]  = ~w[1];
    m[192] = ~w[1];
    m[128] = ~w[0];
    return m;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [2:0]          width_q, width_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic [2:0]          cfg_width_q, cfg_width_d;
  logic [LEN_PRNG-1:0] cfg_mask_q, cfg_mask_d;
  logic                out_valid_q, out_valid_d;
  logic [LEN_PRNG-1:0] out_data_q, out_data_d;
  logic [NUM_REQ-1:0]  out_mode_q, out_mode_d;
  logic                out_last_q, out_last_d;

  logic                prng_ready_c;
  logic [NUM_REQ-1:0]  ack_c;
  logic                gnt_found;
  logic [ID_W-1:0]     gnt_id;
  logic [2:0]          gnt_width;
  logic [LEN_W-1:0]    gnt_len;

  // Round-robin pick: first active request strictly after the last grant, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_width = 3'b111;
    gnt_len   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!gnt_found && req_i[i] && (((32'(rr_q) + k) % NUM_REQ) == i)) begin
          gnt_found = 1'b1;
          gnt_id    = ID_W'(i);
          gnt_width = coerce_width(width_i[3*i +: 3]);
          gnt_len   = len_i[LEN_W*i +: LEN_W];
        end
      end
    end
  end

  // Next-state and datapath control for grant, reconfigure, stream and drain.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    width_d      = width_q;
    rem_d        = rem_q;
    cfg_valid_d  = cfg_valid_q;
    cfg_width_d  = cfg_width_q;
    cfg_mask_d   = cfg_mask_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_mode_d   = out_mode_q;
    out_last_d   = out_last_q;
    prng_ready_c = 1'b0;
    ack_c        = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          id_d    = gnt_id;
          rr_d    = gnt_id;
          width_d = gnt_width;
          rem_d   = (gnt_len == '0) ? LEN_W'(1) : gnt_len;
          state_d = (cfg_valid_q && (gnt_width == cfg_width_q)) ? S_STREAM : S_CONFIG;
        end
      end
      S_CONFIG: begin
        cfg_width_d = width_q;
        cfg_mask_d  = make_carry_mask(width_q);
        cfg_valid_d = 1'b1;
        state_d     = S_STREAM;
      end
      S_STREAM: begin
        prng_ready_c = !out_valid_q || out_ready_i;
        if (out_valid_q && out_ready_i) begin
          out_valid_d = 1'b0;
        end
        if (prng_ready_c && prng_valid_i) begin
          out_valid_d = 1'b1;
          out_data_d  = prng_data_i;
          out_mode_d  = NUM_REQ'(1) << id_q;
          out_last_d  = (rem_q == LEN_W'(1));
          rem_d       = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready_i) begin
          ack_c       = NUM_REQ'(1) << id_q;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      width_q     <= 3'b111;
      rem_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_width_q <= 3'b111;
      cfg_mask_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      width_q     <= width_d;
      rem_q       <= rem_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_width_q <= cfg_width_d;
      cfg_mask_q  <= cfg_mask_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_last_q  <= out_last_d;
    end
  end

  // Handshake strobes are suppressed while reset is asserted so an aborted burst is never acked.
  assign prng_ready_o     = prng_ready_c && !rst;
  assign ack_o            = rst ? '0 : ack_c;
  assign out_valid_o      = out_valid_q;
  assign out_data_o       = out_data_q;
  assign out_mode_o       = out_mode_q;
  assign out_last_o       = out_last_q;
  assign cfg_width_o      = cfg_width_q;
  assign cfg_carry_mask_o = cfg_mask_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_crg_stream_sched.sv
// Self-checking bench for crg_stream_sched: a transaction-level model predicts the grants,
// beat order, acks and lane configuration. Directed and random scenarios are checked against it.
module tb_crg_stream_sched;

  localparam int unsigned N  = 3;
  localparam int unsigned LW = 8;
  localparam int unsigned DW = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [3*N-1:0]  width_i;
  logic [LW*N-1:0] len_i;
  logic [N-1:0]    ack_o;
  logic            prng_valid_i;
  logic [DW-1:0]   prng_data_i;
  logic            prng_ready_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [DW-1:0]   out_data_o;
  logic [N-1:0]    out_mode_o;
  logic            out_last_o;
  logic [2:0]      cfg_width_o;
  logic [DW-1:0]   cfg_carry_mask_o;
  logic            busy_o;

  logic [2:0]      w_arr [N];
  logic [LW-1:0]   l_arr [N];

  always #5 clk = ~clk;

  // Pack per-requester stimulus arrays onto the flat buses.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      width_i[3*i +: 3]   = w_arr[i];
      len_i[LW*i +: LW]   = l_arr[i];
    end
  end

  crg_stream_sched #(.NUM_REQ(N), .LEN_W(LW), .LEN_PRNG(DW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .width_i(width_i), .len_i(len_i), .ack_o(ack_o),
    .prng_valid_i(prng_valid_i), .prng_data_i(prng_data_i), .prng_ready_o(prng_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_mode_o(out_mode_o), .out_last_o(out_last_o), .cfg_width_o(cfg_width_o),
    .cfg_carry_mask_o(cfg_carry_mask_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase 0 idle, 1 reconfiguration bubble, 2 burst in flight.
  int            m_phase, m_rr, m_id, m_len, m_acc, m_emit;
  bit            m_cfg_valid;
  logic [2:0]    m_cfg_w, m_new_w;
  logic [DW-1:0] m_q[$];
  int            ack_log[$];
  bit            seq_mode;
  bit            auto_drop;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] legal_w(input logic [2:0] w);
    return (w == 3'b000 || w == 3'b100 || w == 3'b110 || w == 3'b111) ? w : 3'b111;
  endfunction

  // Lane boundaries every 32 bits; each boundary breaks unless a wider lane spans it.
  function automatic logic [DW-1:0] mask_of(input logic [2:0] w);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 32; b < DW; b += 32) begin
      if (b % 128 == 0)     m[b] = !w[0];
      else if (b % 64 == 0) m[b] = !w[1];
      else                  m[b] = !w[2];
    end
    return m;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rr = N - 1; m_id = 0; m_len = 0; m_acc = 0; m_emit = 0;
    m_cfg_valid = 1'b0; m_cfg_w = 3'b111; m_new_w = 3'b111;
    m_q.delete();
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit            exp_valid, exp_last, exp_ready, prng_hs, out_hs, rst_c, found;
    logic [N-1:0]  exp_ack, req_c;
    logic [DW-1:0] data_c;
    logic [2:0]    w_c [N];
    logic [LW-1:0] l_c [N];
    @(negedge clk);
    rst_c = rst; req_c = req_i; data_c = prng_data_i; w_c = w_arr; l_c = l_arr;
    exp_valid = (m_acc - m_emit) == 1;
    exp_last  = exp_valid && (m_emit + 1 == m_len);
    exp_ready = !rst_c && m_phase == 2 && m_acc < m_len && (!exp_valid || out_ready_i);
    exp_ack   = (!rst_c && exp_last && out_ready_i) ? (N'(1) << m_id) : '0;
    chk("busy",       DW'(busy_o),       DW'(m_phase != 0));
    chk("out_valid",  DW'(out_valid_o),  DW'(exp_valid));
    chk("prng_ready", DW'(prng_ready_o), DW'(exp_ready));
    chk("ack",        DW'(ack_o),        DW'(exp_ack));
    chk("cfg_width",  DW'(cfg_width_o),  DW'(m_cfg_w));
    chk("cfg_mask",   cfg_carry_mask_o,  mask_of(m_cfg_w));
    if (exp_valid) begin
      chk("out_data", out_data_o,        m_q[0]);
      chk("out_mode", DW'(out_mode_o),   DW'(N'(1) << m_id));
      chk("out_last", DW'(out_last_o),   DW'(exp_last));
    end
    for (int i = 0; i < N; i++) if (ack_o == (N'(1) << i)) ack_log.push_back(i);
    prng_hs = prng_valid_i && exp_ready;
    out_hs  = exp_valid && out_ready_i && !rst_c;
    @(posedge clk);
    if (rst_c) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (!found && req_c[c]) begin
              found = 1'b1; m_id = c; m_rr = c;
              m_len = (l_c[c] == 0) ? 1 : int'(l_c[c]);
              m_new_w = legal_w(w_c[c]);
              m_acc = 0; m_emit = 0;
              m_phase = (m_cfg_valid && m_new_w == m_cfg_w) ? 2 : 1;
            end
          end
        end
        1: begin m_cfg_w = m_new_w; m_cfg_valid = 1'b1; m_phase = 2; end
        default: begin
          if (out_hs)  begin m_emit++; void'(m_q.pop_front()); end
          if (prng_hs) begin m_acc++;  m_q.push_back(data_c); end
          if (m_emit == m_len) m_phase = 0;
        end
      endcase
    end
    #1;
    if (prng_hs) prng_data_i = seq_mode ? prng_data_i + DW'(1) : rnd_data();
    if (auto_drop) req_i = req_i & ~exp_ack;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int target, t;
    target = ack_log.size() + n; t = 0;
    while (ack_log.size() < target && t < budget) begin tick(); t++; end
    chk("ack_timeout", DW'(ack_log.size() >= target), DW'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1; req_i = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; model_reset();
    chk("rst_out_valid", DW'(out_valid_o),  DW'(0));
    chk("rst_out_data",  out_data_o,        DW'(0));
    chk("rst_out_mode",  DW'(out_mode_o),   DW'(0));
    chk("rst_out_last",  DW'(out_last_o),   DW'(0));
    chk("rst_busy",      DW'(busy_o),       DW'(0));
    chk("rst_ack",       DW'(ack_o),        DW'(0));
    chk("rst_cfg_width", DW'(cfg_width_o),  DW'(3'b111));
    chk("rst_cfg_mask",  cfg_carry_mask_o,  DW'(0));
  endtask

  initial begin
    int start, t;
    rst = 1'b1; req_i = '0; prng_valid_i = 1'b1; out_ready_i = 1'b1; prng_data_i = '0;
    seq_mode = 1'b0; auto_drop = 1'b1;
    for (int i = 0; i < N; i++) begin w_arr[i] = 3'b111; l_arr[i] = 8'd1; end
    do_reset();

    // Single request that needs a reconfiguration bubble; data 1,2,3.
    seq_mode = 1'b1; prng_data_i = DW'(1);
    w_arr[0] = 3'b100; l_arr[0] = 8'd3; req_i = 3'b001;
    wait_acks(1, 50);
    chk("t1_ack_id",    DW'(ack_log[ack_log.size()-1]), DW'(0));
    chk("t1_cfg_width", DW'(cfg_width_o), DW'(3'b100));
    seq_mode = 1'b0; prng_data_i = rnd_data();

    // Width 000 twice back to back on requester 1; the second grant skips reconfiguration.
    w_arr[1] = 3'b000; l_arr[1] = 8'd2; req_i = 3'b010;
    wait_acks(1, 50);
    req_i = 3'b010;
    wait_acks(1, 50);
    chk("t2_cfg_mask", cfg_carry_mask_o, mask_of(3'b000));

    // Round-robin fairness with all requesters held high.
    do_reset();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) begin w_arr[i] = 3'b111; l_arr[i] = 8'd1; end
    start = ack_log.size();
    req_i = 3'b111;
    wait_acks(6, 200);
    req_i = '0; auto_drop = 1'b1;
    repeat (3) tick();
    if (ack_log.size() >= start + 6)
      for (int i = 0; i < 6; i++) chk("rr_order", DW'(ack_log[start+i]), DW'(i % 3));

    // Output backpressure for four cycles in the middle of a burst.
    w_arr[0] = 3'b111; l_arr[0] = 8'd4; req_i = 3'b001;
    t = 0;
    while (m_acc < 2 && t < 30) begin tick(); t++; end
    chk("bp_start", DW'(m_acc >= 2), DW'(1));
    out_ready_i = 1'b0;
    repeat (4) tick();
    out_ready_i = 1'b1;
    wait_acks(1, 50);

    // Length 0 and an illegal width: one beat, full-width lanes.
    w_arr[2] = 3'b010; l_arr[2] = 8'd0; req_i = 3'b100;
    wait_acks(1, 50);
    chk("t5_cfg_width", DW'(cfg_width_o), DW'(3'b111));
    chk("t5_cfg_mask",  cfg_carry_mask_o, DW'(0));

    // Reset in the middle of a five-beat burst.
    w_arr[1] = 3'b110; l_arr[1] = 8'd5; req_i = 3'b010;
    t = 0;
    while (m_emit < 2 && t < 40) begin tick(); t++; end
    chk("mid_start", DW'(m_emit >= 2), DW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0; req_i = '0;
    chk("mid_out_valid", DW'(out_valid_o), DW'(0));
    chk("mid_busy",      DW'(busy_o),      DW'(0));
    chk("mid_ack",       DW'(ack_o),       DW'(0));
    chk("mid_cfg_width", DW'(cfg_width_o), DW'(3'b111));
    w_arr[2] = 3'b111; l_arr[2] = 8'd2; req_i = 3'b100;
    wait_acks(1, 50);

    // Random traffic: requests, widths and lengths change freely and are sampled only at grant.
    auto_drop = 1'b0;
    for (int c = 0; c < 600; c++) begin
      req_i        = N'($urandom_range(0, 7));
      prng_valid_i = ($urandom_range(0, 3) != 0);
      out_ready_i  = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        w_arr[i] = 3'($urandom_range(0, 7));
        l_arr[i] = 8'($urandom_range(0, 4));
      end
      tick();
    end
    req_i = '0; prng_valid_i = 1'b1; out_ready_i = 1'b1;
    t = 0;
    while (m_phase != 0 && t < 50) begin tick(); t++; end
    chk("final_idle", DW'(busy_o), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
